// File: rtl/qpu_exu_bjp_commit.sv
// Branch commit consumer: checks each predicted direction and holds a flush/redirect until fetch acks.
// Optional saturating branch/mispredict counters are compiled in with QPU_BJP_CMT_PERF_EN.
module qpu_exu_bjp_commit #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmt_i_valid,
  output logic             cmt_i_ready,
  input  logic             cmt_i_prdt,
  input  logic             cmt_i_rslv,
  input  logic [PC_W-1:0]  cmt_i_pc,
  input  logic [PC_W-1:0]  cmt_i_imm,
  output logic             flush_o_valid,
  input  logic             flush_o_ready,
  output logic [PC_W-1:0]  flush_o_pc,
  output logic             cmt_o_mispred,
  output logic             busy,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_branch_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt
);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] flush_pc_q, flush_pc_d;
  logic [PC_W-1:0] tgt_pc;
  logic            mispred_q;
  logic            accept;
  logic            mispred;

  // Ready is a pure function of state so there is no valid->ready path.
  assign cmt_i_ready   = (state_q == StIdle);
  assign flush_o_valid = (state_q == StFlush);
  assign busy          = (state_q == StFlush);
  assign flush_o_pc    = flush_pc_q;
  assign cmt_o_mispred = mispred_q;

  assign accept  = cmt_i_valid && cmt_i_ready;
  assign mispred = cmt_i_prdt ^ cmt_i_rslv;
  assign tgt_pc  = cmt_i_rslv ? (cmt_i_pc + cmt_i_imm) : (cmt_i_pc + PC_W'(4));

  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    unique case (state_q)
      StIdle: begin
        if (accept && mispred) begin
          state_d    = StFlush;
          flush_pc_d = tgt_pc;
        end
      end
      StFlush: begin
        if (flush_o_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      flush_pc_q <= '0;
      mispred_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
      mispred_q  <= accept && mispred;
    end
  end

`ifdef QPU_BJP_CMT_PERF_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (perf_clr) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (accept) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispred && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign perf_branch_cnt  = branch_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr  = perf_clr;
  assign perf_branch_cnt  = '0;
  assign perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_qpu_exu_bjp_commit.sv
// Self-checking bench for qpu_exu_bjp_commit: vector table of branches plus handshake/reset sequences.
module tb_qpu_exu_bjp_commit;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmt_i_valid, cmt_i_ready, cmt_i_prdt, cmt_i_rslv;
  logic [PC_W-1:0]  cmt_i_pc, cmt_i_imm;
  logic             flush_o_valid, flush_o_ready;
  logic [PC_W-1:0]  flush_o_pc;
  logic             cmt_o_mispred, busy, perf_clr;
  logic [CNT_W-1:0] perf_branch_cnt, perf_mispred_cnt;

  always #5 clk = ~clk;

  qpu_exu_bjp_commit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmt_i_valid      (cmt_i_valid),
    .cmt_i_ready      (cmt_i_ready),
    .cmt_i_prdt       (cmt_i_prdt),
    .cmt_i_rslv       (cmt_i_rslv),
    .cmt_i_pc         (cmt_i_pc),
    .cmt_i_imm        (cmt_i_imm),
    .flush_o_valid    (flush_o_valid),
    .flush_o_ready    (flush_o_ready),
    .flush_o_pc       (flush_o_pc),
    .cmt_o_mispred    (cmt_o_mispred),
    .busy             (busy),
    .perf_clr         (perf_clr),
    .perf_branch_cnt  (perf_branch_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );

  typedef struct {
    logic            prdt;
    logic            rslv;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] imm;
    logic            exp_flush;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state kept by the bench
  logic            m_busy  = 1'b0;
  logic            m_pulse = 1'b0;
  logic [PC_W-1:0] m_pc    = '0;
  int              m_br    = 0;
  int              m_mp    = 0;
  logic [PC_W-1:0] sb_q[$];
  logic [PC_W-1:0] nxt_exp_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_next(input int cnt, input bit inc);
    if (perf_clr) return 0;
    if (inc && cnt != (1 << CNT_W) - 1) return cnt + 1;
    return cnt;
  endfunction

  // One clock: update the model from the current inputs, step, then compare every output.
  task automatic tick();
    logic acc, mis;
    logic [PC_W-1:0] popped;
    acc = cmt_i_valid && !m_busy;
    mis = cmt_i_prdt ^ cmt_i_rslv;
    if (m_busy && flush_o_ready && rst_n) begin
      if (sb_q.size() == 0) begin
        check("flush_unexpected", 64'(flush_o_pc), 64'hdead);
      end else begin
        popped = sb_q.pop_front();
        check("flush_pc_at_handshake", 64'(flush_o_pc), 64'(popped));
      end
    end
    if (acc && mis && rst_n) sb_q.push_back(nxt_exp_pc);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 1'b0; m_pulse = 1'b0; m_pc = '0; m_br = 0; m_mp = 0;
      sb_q.delete();
    end else begin
      m_br    = cnt_next(m_br, acc);
      m_mp    = cnt_next(m_mp, acc && mis);
      m_pulse = acc && mis;
      if (acc && mis) begin
        m_busy = 1'b1;
        m_pc   = nxt_exp_pc;
      end else if (m_busy && flush_o_ready) begin
        m_busy = 1'b0;
      end
    end
    check("cmt_i_ready", 64'(cmt_i_ready), 64'(!m_busy));
    check("flush_o_valid", 64'(flush_o_valid), 64'(m_busy));
    check("busy", 64'(busy), 64'(m_busy));
    check("cmt_o_mispred", 64'(cmt_o_mispred), 64'(m_pulse));
    check("flush_o_pc", 64'(flush_o_pc), 64'(m_pc));
`ifdef QPU_BJP_CMT_PERF_EN
    check("perf_branch_cnt", 64'(perf_branch_cnt), 64'(m_br));
    check("perf_mispred_cnt", 64'(perf_mispred_cnt), 64'(m_mp));
`else
    check("perf_branch_cnt", 64'(perf_branch_cnt), 64'd0);
    check("perf_mispred_cnt", 64'(perf_mispred_cnt), 64'd0);
`endif
  endtask

  task automatic commit(input vec_t v);
    cmt_i_valid = 1'b1;
    cmt_i_prdt  = v.prdt;
    cmt_i_rslv  = v.rslv;
    cmt_i_pc    = v.pc;
    cmt_i_imm   = v.imm;
    nxt_exp_pc  = v.exp_pc;
    tick();
    cmt_i_valid = 1'b0;
    check("flush_expected", 64'(flush_o_valid), 64'(v.exp_flush));
  endtask

  // Hold fetch stalled for `hold` cycles, then ack.
  task automatic ack(input int hold);
    flush_o_ready = 1'b0;
    for (int i = 0; i < hold; i++) tick();
    flush_o_ready = 1'b1;
    tick();
    flush_o_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0120};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0104};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 32'h0000_0010};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFF0, 1'b1, 32'h0000_0FF0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_0040, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_3000, 32'h0000_0040, 1'b0, 32'h0000_0000};

    rst_n = 1'b0; cmt_i_valid = 1'b0; cmt_i_prdt = 1'b0; cmt_i_rslv = 1'b0;
    cmt_i_pc = '0; cmt_i_imm = '0; flush_o_ready = 1'b0; perf_clr = 1'b0; nxt_exp_pc = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back correct predictions, valid held high
    cmt_i_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmt_i_prdt = i[0];
      cmt_i_rslv = i[0];
      cmt_i_pc   = 32'h400 + 32'(4 * i);
      tick();
    end
    cmt_i_valid = 1'b0;
`ifdef QPU_BJP_CMT_PERF_EN
    check("b2b_branch_cnt", 64'(perf_branch_cnt), 64'd8);
    check("b2b_mispred_cnt", 64'(perf_mispred_cnt), 64'd0);
`endif

    // flush_o_ready with no pending flush must be ignored
    flush_o_ready = 1'b1;
    tick();
    flush_o_ready = 1'b0;

    // Table: each mispredict acked after 0..2 stalls, next commit right after the ack edge
    foreach (vecs[i]) begin
      commit(vecs[i]);
      if (vecs[i].exp_flush) ack(i % 3);
    end

    // Long stall then immediate new commit in the cycle after the ack
    commit(vecs[0]);
    ack(5);
    commit(vecs[1]);
    ack(0);

    // Reset while in FLUSH drops the request
    commit(vecs[3]);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_flush_pc", 64'(flush_o_pc), 64'd0);
    check("rst_ready", 64'(cmt_i_ready), 64'd1);
    tick();

    // Saturation: 20 mispredicts into 4-bit counters
    for (int i = 0; i < 20; i++) begin
      commit(vecs[i % 4]);
      ack(0);
    end
`ifdef QPU_BJP_CMT_PERF_EN
    check("sat_branch_cnt", 64'(perf_branch_cnt), 64'hF);
    check("sat_mispred_cnt", 64'(perf_mispred_cnt), 64'hF);
`endif

    // Clear in the same cycle as an accept wins
    perf_clr = 1'b1;
    commit(vecs[1]);
    perf_clr = 1'b0;
    check("clr_branch_cnt", 64'(perf_branch_cnt), 64'd0);
    check("clr_mispred_cnt", 64'(perf_mispred_cnt), 64'd0);
    ack(1);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
